// File: rtl/poly_voice_pkg.sv
// rtl/poly_voice_pkg.sv - shared waveform codes, widths and LFSR helper for poly_voice_pdm
package poly_voice_pkg;

    typedef enum logic [1:0] {
        WAVE_PULSE = 2'd0,
        WAVE_SAW   = 2'd1,
        WAVE_TRI   = 2'd2,
        WAVE_NOISE = 2'd3
    } wave_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam int PW_W  = 12;
    localparam int SMP_W = 8;
    localparam int ENV_W = 8;

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting towards the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/poly_voice_channel.sv
// rtl/poly_voice_channel.sv - one voice: phase accumulator, noise LFSR, linear envelope, scaled waveform
module poly_voice_channel
    import poly_voice_pkg::*;
#(
    parameter int ACC_W        = 16,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [ACC_W-1:0] freq,
    input  logic [PW_W-1:0]  pulsewidth,
    input  logic [1:0]       wave_sel,
    input  logic             gate,
    input  logic             sync_clr,
    output logic [SMP_W-1:0] sample,
    output logic             wrap
);

    localparam logic [ENV_W:0] ATK = ATTACK_STEP[ENV_W:0];
    localparam logic [ENV_W:0] REL = RELEASE_STEP[ENV_W:0];

    logic [ACC_W-1:0] acc;
    logic [ENV_W-1:0] env;
    logic [7:0]       lfsr;

    logic [ACC_W:0]   acc_sum;
    logic [ENV_W:0]   env_up;
    logic [ENV_W-1:0] env_next;
    logic [PW_W-1:0]  phase_hi;
    logic [7:0]       saw;
    logic [7:0]       tri_wave;
    logic [7:0]       wave;
    logic [15:0]      product;

    assign acc_sum = {1'b0, acc} + {1'b0, freq};
    assign wrap    = acc_sum[ACC_W];

    assign env_up = {1'b0, env} + ATK;

    always_comb begin
        env_next = env;
        if (gate) begin
            env_next = env_up[ENV_W] ? '1 : env_up[ENV_W-1:0];
        end else if ({1'b0, env} > REL) begin
            env_next = env - REL[ENV_W-1:0];
        end else begin
            env_next = '0;
        end
    end

    assign phase_hi = acc[ACC_W-1 -: PW_W];
    assign saw      = acc[ACC_W-1 -: 8];
    // second half of the cycle mirrors the first to form the falling edge
    assign tri_wave = acc[ACC_W-2 -: 8] ^ {8{acc[ACC_W-1]}};

    always_comb begin
        wave = '0;
        case (wave_e'(wave_sel))
            WAVE_PULSE: wave = (phase_hi < pulsewidth) ? 8'hFF : 8'h00;
            WAVE_SAW:   wave = saw;
            WAVE_TRI:   wave = tri_wave;
            WAVE_NOISE: wave = lfsr;
            default:    wave = '0;
        endcase
    end

    assign product = {8'd0, wave} * {8'd0, env};
    assign sample  = product[15:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            env  <= '0;
            lfsr <= LFSR_SEED;
        end else if (tick) begin
            acc <= sync_clr ? '0 : acc_sum[ACC_W-1:0];
            env <= env_next;
            if (wrap) begin
                lfsr <= lfsr_next(lfsr);
            end
        end
    end

endmodule

// File: rtl/poly_voice_pdm.sv
// rtl/poly_voice_pdm.sv - multi-voice synth mixer with sigma-delta PDM output; POLY_VOICE_HARD_SYNC_EN adds hard sync
module poly_voice_pdm
    import poly_voice_pkg::*;
#(
    parameter int  NUM_VOICES   = 3,
    parameter int  ACC_W        = 16,
    parameter int  ATTACK_STEP  = 8,
    parameter int  RELEASE_STEP = 4,
    localparam int MIX_W        = 8 + $clog2(NUM_VOICES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic [NUM_VOICES*ACC_W-1:0] freq,
    input  logic [NUM_VOICES*PW_W-1:0]  pulsewidth,
    input  logic [NUM_VOICES*2-1:0]     wave_sel,
    input  logic [NUM_VOICES-1:0]       gate,
    input  logic [NUM_VOICES-1:0]       sync_en,
    output logic [MIX_W-1:0]            sample_out,
    output logic                        pdm_out
);

    logic [NUM_VOICES-1:0] wrap;
    logic [NUM_VOICES-1:0] sync_clr;
    logic [SMP_W-1:0]      sample [NUM_VOICES];
    logic [MIX_W-1:0]      mix_sum;
    logic [MIX_W-1:0]      mix_reg;
    logic [MIX_W-1:0]      sd_acc;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        poly_voice_channel #(
            .ACC_W       (ACC_W),
            .ATTACK_STEP (ATTACK_STEP),
            .RELEASE_STEP(RELEASE_STEP)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .freq       (freq[i*ACC_W +: ACC_W]),
            .pulsewidth (pulsewidth[i*PW_W +: PW_W]),
            .wave_sel   (wave_sel[i*2 +: 2]),
            .gate       (gate[i]),
            .sync_clr   (sync_clr[i]),
            .sample     (sample[i]),
            .wrap       (wrap[i])
        );
    end

`ifdef POLY_VOICE_HARD_SYNC_EN
    // each voice is slaved to the wrap of the voice below it, voice 0 to the last
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_sync
        assign sync_clr[i] = sync_en[i] & wrap[(i + NUM_VOICES - 1) % NUM_VOICES];
    end
`else
    logic unused_sync;
    assign sync_clr    = '0;
    assign unused_sync = ^{sync_en, wrap};
`endif

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            mix_sum = mix_sum + MIX_W'(sample[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_reg <= '0;
            sd_acc  <= '0;
            pdm_out <= 1'b0;
        end else begin
            if (tick) begin
                mix_reg <= mix_sum;
            end
            // carry out of the accumulator is the PDM bit
            {pdm_out, sd_acc} <= {1'b0, sd_acc} + {1'b0, mix_reg};
        end
    end

    assign sample_out = mix_reg;

endmodule

// File: tb/tb_poly_voice_pdm.sv
// tb/tb_poly_voice_pdm.sv - scoreboard bench for poly_voice_pdm
module tb_poly_voice_pdm;

    localparam int NV = 3;
    localparam int AW = 16;
    localparam int MW = 8 + $clog2(NV + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0;
    logic [NV*AW-1:0]  freq = '0;
    logic [NV*12-1:0]  pulsewidth = '0;
    logic [NV*2-1:0]   wave_sel = '0;
    logic [NV-1:0]     gate = '0;
    logic [NV-1:0]     sync_en = '0;
    logic [MW-1:0]     sample_out;
    logic              pdm_out;

    int n_cmp = 0;
    int n_bad = 0;

    int m_acc [NV];
    int m_env [NV];
    int m_lfsr[NV];
    bit m_wrap[NV];
    int m_mix;
    int exp_q[$];

    poly_voice_pdm #(
        .NUM_VOICES  (NV),
        .ACC_W       (AW),
        .ATTACK_STEP (8),
        .RELEASE_STEP(4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .freq       (freq),
        .pulsewidth (pulsewidth),
        .wave_sel   (wave_sel),
        .gate       (gate),
        .sync_en    (sync_en),
        .sample_out (sample_out),
        .pdm_out    (pdm_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_acc[v]  = 0;
            m_env[v]  = 0;
            m_lfsr[v] = 1;
            m_wrap[v] = 1'b0;
        end
        m_mix = 0;
    endtask

    task automatic model_step();
        int sum;
        int wv;
        int a;
        int fb;
        int nxt[NV];
        bit s;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            a = m_acc[v];
            case (wave_sel[v*2 +: 2])
                2'd0:    wv = ((a >> 4) < int'(pulsewidth[v*12 +: 12])) ? 255 : 0;
                2'd1:    wv = a >> 8;
                2'd2:    wv = (a < 32768) ? ((a >> 7) & 255) : 255 - ((a >> 7) & 255);
                default: wv = m_lfsr[v];
            endcase
            sum += (wv * m_env[v]) >> 8;
        end
        for (int v = 0; v < NV; v++) begin
            nxt[v]    = m_acc[v] + int'(freq[v*AW +: AW]);
            m_wrap[v] = (nxt[v] > 65535);
        end
        for (int v = 0; v < NV; v++) begin
            s = 1'b0;
`ifdef POLY_VOICE_HARD_SYNC_EN
            s = sync_en[v] && m_wrap[(v + NV - 1) % NV];
`endif
            m_acc[v] = s ? 0 : (nxt[v] & 65535);
            if (m_wrap[v]) begin
                fb = ((m_lfsr[v] >> 7) ^ (m_lfsr[v] >> 5) ^ (m_lfsr[v] >> 4) ^ (m_lfsr[v] >> 3)) & 1;
                m_lfsr[v] = ((m_lfsr[v] << 1) & 255) | fb;
            end
            if (gate[v]) m_env[v] = (m_env[v] + 8 > 255) ? 255 : m_env[v] + 8;
            else         m_env[v] = (m_env[v] - 4 < 0) ? 0 : m_env[v] - 4;
        end
        m_mix = sum;
    endtask

    // one tick strobe after `gap` idle clocks; expected mix pushed at stimulus time
    task automatic do_tick(input int gap);
        repeat (gap) @(negedge clk);
        tick = 1'b1;
        model_step();
        exp_q.push_back(m_mix);
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        int ones;
        rst_n = 1'b0;
        tick  = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();
        n_cmp++;
        if (sample_out !== '0) begin
            n_bad++;
            $display("FAIL reset_sample got=%0d want=0", sample_out);
        end
        n_cmp++;
        if (pdm_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pdm got=%b want=0", pdm_out);
        end
        rst_n = 1'b1;
        tick  = 1'b0;
        ones  = 0;
        repeat (100) begin
            @(negedge clk);
            if (pdm_out !== 1'b0) ones++;
        end
        n_cmp++;
        if (ones != 0) begin
            n_bad++;
            $display("FAIL idle_pdm got=%0d nonzero bits want=0", ones);
        end
        n_cmp++;
        if (sample_out !== '0) begin
            n_bad++;
            $display("FAIL idle_sample got=%0d want=0", sample_out);
        end
    endtask

    task automatic test_saw_attack();
        int e;
        wave_sel        = '0;
        wave_sel[1:0]   = 2'd1;
        freq            = '0;
        freq[15:0]      = 16'h0100;
        pulsewidth      = '0;
        gate            = 3'b001;
        for (int k = 1; k <= 256; k++) begin
            do_tick(23);
            e = exp_q.pop_front();
            n_cmp++;
            if (sample_out !== MW'(e)) begin
                n_bad++;
                $display("FAIL saw_sample tick=%0d got=%0d want=%0d", k, sample_out, e);
            end
            if (k == 31 || k == 32 || k == 256) begin
                n_cmp++;
                if (u_dut.g_voice[0].u_chan.env !== ((k == 31) ? 8'd248 : 8'd255)) begin
                    n_bad++;
                    $display("FAIL saw_env tick=%0d got=%0d want=%0d", k,
                             u_dut.g_voice[0].u_chan.env, (k == 31) ? 248 : 255);
                end
            end
        end
        n_cmp++;
        if (u_dut.g_voice[0].u_chan.acc !== 16'h0000) begin
            n_bad++;
            $display("FAIL saw_acc_wrap got=%h want=0000", u_dut.g_voice[0].u_chan.acc);
        end
    endtask

    task automatic test_pulse();
        int e;
        int c;
        wave_sel[1:0]    = 2'd0;
        freq[15:0]       = 16'h1000;
        pulsewidth[11:0] = 12'h800;
        for (int k = 1; k <= 32; k++) begin
            do_tick(3);
            e = exp_q.pop_front();
            n_cmp++;
            if (sample_out !== MW'(e)) begin
                n_bad++;
                $display("FAIL pulse_sample tick=%0d got=%0d want=%0d", k, sample_out, e);
            end
            c = ((((k - 1) / 8) % 2) == 0) ? 254 : 0;
            n_cmp++;
            if (sample_out !== MW'(c)) begin
                n_bad++;
                $display("FAIL pulse_square tick=%0d got=%0d want=%0d", k, sample_out, c);
            end
        end
    endtask

    task automatic test_release();
        int e;
        int want_env;
        gate       = 3'b000;
        freq[15:0] = 16'h0000;
        for (int k = 1; k <= 66; k++) begin
            do_tick(3);
            e = exp_q.pop_front();
            n_cmp++;
            if (sample_out !== MW'(e)) begin
                n_bad++;
                $display("FAIL release_sample tick=%0d got=%0d want=%0d", k, sample_out, e);
            end
            if (k == 1 || k == 2 || k == 63 || k == 64) begin
                want_env = (k == 64) ? 0 : 255 - 4 * k;
                n_cmp++;
                if (u_dut.g_voice[0].u_chan.env !== 8'(want_env)) begin
                    n_bad++;
                    $display("FAIL release_env tick=%0d got=%0d want=%0d", k,
                             u_dut.g_voice[0].u_chan.env, want_env);
                end
            end
            if (k == 65) begin
                n_cmp++;
                if (sample_out !== '0) begin
                    n_bad++;
                    $display("FAIL release_silent got=%0d want=0", sample_out);
                end
            end
        end
    endtask

    task automatic test_pdm_density();
        int e;
        int ones;
        gate             = 3'b001;
        wave_sel[1:0]    = 2'd0;
        freq[15:0]       = 16'h0000;
        pulsewidth[11:0] = 12'hFFF;
        for (int k = 1; k <= 33; k++) begin
            do_tick(3);
            e = exp_q.pop_front();
            n_cmp++;
            if (sample_out !== MW'(e)) begin
                n_bad++;
                $display("FAIL pdm_setup_sample tick=%0d got=%0d want=%0d", k, sample_out, e);
            end
        end
        n_cmp++;
        if (sample_out !== MW'(254)) begin
            n_bad++;
            $display("FAIL pdm_level got=%0d want=254", sample_out);
        end
        for (int w = 0; w < 2; w++) begin
            ones = 0;
            repeat (1024) begin
                @(negedge clk);
                if (pdm_out === 1'b1) ones++;
            end
            n_cmp++;
            if (ones != 254) begin
                n_bad++;
                $display("FAIL pdm_density window=%0d got=%0d ones want=254", w, ones);
            end
        end
    endtask

    task automatic test_noise();
        int e;
        int lt[9] = '{1, 1, 2, 2, 4, 4, 8, 8, 17};
        wave_sel[5:4] = 2'd3;
        freq[47:32]   = 16'h8000;
        gate[2]       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            do_tick(3);
            e = exp_q.pop_front();
            n_cmp++;
            if (sample_out !== MW'(e)) begin
                n_bad++;
                $display("FAIL noise_sample tick=%0d got=%0d want=%0d", k, sample_out, e);
            end
            n_cmp++;
            if (u_dut.g_voice[2].u_chan.lfsr !== 8'(lt[k])) begin
                n_bad++;
                $display("FAIL noise_lfsr tick=%0d got=%h want=%h", k,
                         u_dut.g_voice[2].u_chan.lfsr, lt[k]);
            end
        end
    endtask

    task automatic test_sync();
        int e;
        wave_sel[1:0] = 2'd1;
        wave_sel[3:2] = 2'd2;
        freq[15:0]    = 16'h4000;
        freq[31:16]   = 16'h0123;
        gate          = 3'b111;
        sync_en       = 3'b010;
        for (int k = 1; k <= 40; k++) begin
            do_tick(2);
            e = exp_q.pop_front();
            n_cmp++;
            if (sample_out !== MW'(e)) begin
                n_bad++;
                $display("FAIL sync_sample tick=%0d got=%0d want=%0d", k, sample_out, e);
            end
            n_cmp++;
            if (u_dut.g_voice[1].u_chan.acc !== 16'(m_acc[1])) begin
                n_bad++;
                $display("FAIL sync_acc1 tick=%0d got=%h want=%h", k,
                         u_dut.g_voice[1].u_chan.acc, m_acc[1]);
            end
`ifdef POLY_VOICE_HARD_SYNC_EN
            if (m_wrap[0]) begin
                n_cmp++;
                if (u_dut.g_voice[1].u_chan.acc !== 16'h0000) begin
                    n_bad++;
                    $display("FAIL sync_reset tick=%0d got=%h want=0000", k,
                             u_dut.g_voice[1].u_chan.acc);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_saw_attack();
        test_pulse();
        test_release();
        test_pdm_density();
        test_noise();
        test_sync();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
